pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 160; width of the opaque per-instruction payload (control plus datapath fields).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000; out_pc value after reset.
REQ-003 SHALL have parameter CNT_W, default 16; width of the stall counter.
REQ-004 SHALL use clock clk and reset reset, synchronous, active-high.
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 sync reset; flush in 1 exception/eret kill; in_valid in 1 upstream beat valid; in_allowin out 1 stage can accept; in_data in DATA_W payload; in_pc in 32 upstream PC; in_bd in 1 upstream branch-delay flag; out_valid out 1 downstream beat valid; out_allowin in 1 downstream can accept; out_data out DATA_W payload; out_pc out 32 PC (tracks bubbles); out_bd out 1 BD flag (tracks bubbles); stall_cnt out CNT_W stall cycles; stall_clr in 1 zero counter.

Function
REQ-006 SHALL transfer a beat in when in_valid && in_allowin, and out when out_valid && out_allowin, both at posedge clk.
REQ-007 SHALL deliver an accepted beat at the outputs one cycle after acceptance when the stage was empty (latency 1).
REQ-008 SHALL preserve beat order; no beat dropped or duplicated except by flush or reset.
REQ-009 SHALL hold out_data, out_pc, out_bd, out_valid stable while out_valid && !out_allowin.
REQ-010 SHALL load out_pc/out_bd from in_pc/in_bd whenever the output register is loaded from the input, including when in_valid=0 (bubble), so exception logic sees the PC/BD of the slot.
REQ-011 SHALL leave out_data unchanged on a bubble load (only out_valid cleared).
REQ-012 SHALL, on flush=1, clear all entries' valid at the same edge; the beat offered that cycle is discarded; out_pc/out_bd still load per REQ-010 if the output register is loadable.
REQ-013 SHALL increment stall_cnt by 1 each cycle out_valid && !out_allowin && !flush, saturating at all-ones (no wrap).
REQ-014 SHALL zero stall_cnt when stall_clr=1; stall_clr has priority over increment.
REQ-015 Without skid (see Configuration): in_allowin = !out_valid || out_allowin (combinational); single entry; states EMPTY/FULL.
REQ-016 With skid: two entries (main feeding outputs, skid); in_allowin = !skid_valid, registered, no combinational path from out_allowin.
REQ-017 With skid, states EMPTY(0 valid), ONE(main valid), TWO(both valid); transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE->ONE on accept with drain; TWO->ONE on drain (skid moves to main, no accept possible); any->EMPTY on flush.
REQ-018 With skid, a drain and accept in the same cycle in ONE SHALL place the new beat in main directly.

Reset
REQ-019 SHALL on reset set out_valid=0, skid valid=0, out_data=0, out_pc=RESET_PC, out_bd=0, stall_cnt=0; in_allowin=1 the cycle after reset.
REQ-020 SHALL give reset priority over flush, stall_clr and all transfers; a beat offered during reset is discarded.
REQ-021 SHALL not require reset of skid payload storage.

Configuration
REQ-022 SHALL compile the skid entry and registered in_allowin (REQ-016..018) only when macro PIPE_STAGE_SKID_EN is defined.
REQ-023 SHALL, without PIPE_STAGE_SKID_EN, implement REQ-015 only, cycle-identical to a plain valid/allowin pipeline register.

Verification
REQ-024 Reset then in_valid=1, in_data=0x5, in_pc=0x3004, out_allowin=1 -> next cycle out_valid=1, out_data=0x5, out_pc=0x3004; before that out_pc=0x3000.
REQ-025 Bubble in_valid=0, in_pc=0x3010, in_bd=1, stage empty -> next cycle out_valid=0, out_pc=0x3010, out_bd=1, out_data unchanged.
REQ-026 Beat held, out_allowin=0 for 5 cycles -> outputs stable, stall_cnt=5; then stall_clr=1 -> stall_cnt=0 next cycle.
REQ-027 Skid build: beats A,B sent with out_allowin=0 -> in_allowin=0 after B; out_allowin=1 -> A then B out in order, in_allowin=1 one cycle after A drains.
REQ-028 Flush with both entries full and new beat offered -> next cycle out_valid=0, in_allowin=1, no beat ever emitted from them.
REQ-029 stall_cnt at all-ones with stall persisting -> remains all-ones (CNT_W=4: stays 4'hF).

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with valid/allowin handshake, bubble PC/BD tracking and stall counter.
// Optional skid entry with registered in_allowin when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_buf #(
  parameter int          DATA_W   = 160,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_pc;
  logic              r_bd;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_load;
  logic              w_acc;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_sk_data;
  logic [31:0]       r_sk_pc;
  logic              r_sk_bd;
  logic              w_drain;

  assign out_valid  = (r_state != S_EMPTY);
  assign in_allowin = (r_state != S_TWO);
  assign w_load     = !out_valid || out_allowin;
  assign w_drain    = out_valid && out_allowin;
  assign w_acc      = in_valid && in_allowin && !flush;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_acc) w_next = S_ONE;
        S_ONE: begin
          if (w_acc && !w_drain)      w_next = S_TWO;
          else if (!w_acc && w_drain) w_next = S_EMPTY;
        end
        S_TWO: if (w_drain) w_next = S_ONE;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Main refills from skid first; otherwise from the input slot (beat or bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_pc   <= RESET_PC;
      r_bd   <= 1'b0;
    end else if (w_load) begin
      if (r_state == S_TWO && !flush) begin
        r_data <= r_sk_data;
        r_pc   <= r_sk_pc;
        r_bd   <= r_sk_bd;
      end else begin
        r_pc <= in_pc;
        r_bd <= in_bd;
        if (w_acc) r_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && !w_load) begin
      r_sk_data <= in_data;
      r_sk_pc   <= in_pc;
      r_sk_bd   <= in_bd;
    end
  end

`else

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_next;

  assign out_valid  = (r_state == S_FULL);
  assign w_load     = !out_valid || out_allowin;
  assign in_allowin = w_load;
  assign w_acc      = in_valid && w_load && !flush;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush)       w_next = S_EMPTY;
    else if (w_load) w_next = w_acc ? S_FULL : S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_pc   <= RESET_PC;
      r_bd   <= 1'b0;
    end else if (w_load) begin
      r_pc <= in_pc;
      r_bd <= in_bd;
      if (w_acc) r_data <= in_data;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (stall_clr)
      r_cnt <= '0;
    else if (out_valid && !out_allowin && !flush && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_data  = r_data;
  assign out_pc    = r_pc;
  assign out_bd    = r_bd;
  assign stall_cnt = r_cnt;

endmodule
